// File: rtl/ysyx_22050133_fwd_ctrl_pkg.sv
// rtl/ysyx_22050133_fwd_ctrl_pkg.sv - shared bypass select encoding for the forwarding controller
//
// Contents:
//   fwd_sel_e : 2-bit operand source select consumed by the execute unit.
//               Code 3 is never produced.
package ysyx_22050133_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,  // register-file read data
    FWD_WB  = 2'd1,  // result held in the WB stage
    FWD_MEM = 2'd2   // result held in the MEM stage
  } fwd_sel_e;

endpackage

// File: rtl/ysyx_22050133_fwd_match.sv
// rtl/ysyx_22050133_fwd_match.sv - compares one source operand against the ex/mem shadow slots
//
// Ports:
//   src, src_used                  : source register index and whether the instruction reads it
//   ex_valid/ex_rd/ex_regwrite/ex_load : producer currently headed into EX
//   mem_valid/mem_rd/mem_regwrite  : producer currently headed into MEM
//   sel                            : bypass select for this source (fwd_sel_e encoding)
//   loaduse                        : the ex-slot producer is a load this source depends on
module ysyx_22050133_fwd_match
  import ysyx_22050133_fwd_ctrl_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src,
  input  logic            src_used,
  input  logic            ex_valid,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_load,
  input  logic            mem_valid,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  output logic [1:0]      sel,
  output logic            loaduse
);

  logic ex_hit;
  logic mem_hit;

  // x0 is hardwired to zero, so a producer targeting it never forwards.
  assign ex_hit  = src_used & ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == src);
  assign mem_hit = src_used & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == src);

  // The ex-slot producer is younger than the mem-slot one, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

  assign loaduse = ex_hit & ex_load;

endmodule

// File: rtl/ysyx_22050133_fwd_ctrl.sv
// rtl/ysyx_22050133_fwd_ctrl.sv - ID/EX forwarding selects, load-use stall, flush and freeze control
//
// Ports:
//   clk, rst                         : core clock, asynchronous active-low reset
//   id_valid                         : ID holds a real instruction
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : source indices and read flags
//   id_rd, id_regwrite, id_load, id_store : destination and instruction class
//   ex_redirect                      : EX instruction redirects the PC (flush)
//   mem_stall                        : memory stage busy, whole pipeline frozen
//   forward_ALUSrc1/2, forward_wdataSrc : EX-aligned bypass selects (registered)
//   stall_id, bubble_ex              : combinational load-use stall / bubble request
//   stall_cnt                        : number of load-use stall cycles taken
module ysyx_22050133_fwd_ctrl
  import ysyx_22050133_fwd_ctrl_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_load,
  input  logic            id_store,
  input  logic            ex_redirect,
  input  logic            mem_stall,
  output logic [1:0]      forward_ALUSrc1,
  output logic [1:0]      forward_ALUSrc2,
  output logic [1:0]      forward_wdataSrc,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic [CNTW-1:0] stall_cnt
);

  // Shadow slots. Only the ex slot needs its load flag (load-use is only
  // possible against the instruction directly ahead). The retiring WB entry is
  // not kept at all: the register file writes through on the same edge, so
  // nothing would ever consult it.
  logic            ex_valid;
  logic [REGW-1:0] ex_rd;
  logic            ex_regwrite;
  logic            ex_load;
  logic            mem_valid;
  logic [REGW-1:0] mem_rd;
  logic            mem_regwrite;

  logic [1:0] sel_rs1;
  logic [1:0] sel_rs2_alu;
  logic [1:0] sel_rs2_st;
  logic       lu_rs1;
  logic       lu_rs2_alu;
  logic       lu_rs2_st;

  logic flush;
  logic load_use;
  logic capture;

  // For a store rs2 is store data and the ALU takes the immediate, so rs2
  // feeds exactly one of the two rs2 comparators.
  ysyx_22050133_fwd_match #(.REGW(REGW)) u_match_rs1 (
    .src          (id_rs1),
    .src_used     (id_use_rs1),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_load      (ex_load),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (sel_rs1),
    .loaduse      (lu_rs1)
  );

  ysyx_22050133_fwd_match #(.REGW(REGW)) u_match_rs2_alu (
    .src          (id_rs2),
    .src_used     (id_use_rs2 & ~id_store),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_load      (ex_load),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (sel_rs2_alu),
    .loaduse      (lu_rs2_alu)
  );

  ysyx_22050133_fwd_match #(.REGW(REGW)) u_match_rs2_st (
    .src          (id_rs2),
    .src_used     (id_use_rs2 & id_store),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_load      (ex_load),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (sel_rs2_st),
    .loaduse      (lu_rs2_st)
  );

  // Priority: freeze > flush > load-use. A redirect seen during a freeze is
  // ignored here; the source keeps it asserted until the freeze lifts.
  assign flush    = ex_redirect & ~mem_stall;
  assign load_use = id_valid & (lu_rs1 | lu_rs2_alu | lu_rs2_st) & ~flush & ~mem_stall;
  assign capture  = id_valid & ~flush & ~load_use;

  assign stall_id  = load_use;
  assign bubble_ex = load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid         <= 1'b0;
      ex_rd            <= '0;
      ex_regwrite      <= 1'b0;
      ex_load          <= 1'b0;
      mem_valid        <= 1'b0;
      mem_rd           <= '0;
      mem_regwrite     <= 1'b0;
      forward_ALUSrc1  <= FWD_RF;
      forward_ALUSrc2  <= FWD_RF;
      forward_wdataSrc <= FWD_RF;
      stall_cnt        <= '0;
    end else if (!mem_stall) begin
      // The instruction leaving EX always advances, including a redirecting one.
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;

      if (capture) begin
        ex_valid         <= 1'b1;
        ex_rd            <= id_rd;
        ex_regwrite      <= id_regwrite;
        ex_load          <= id_load;
        forward_ALUSrc1  <= sel_rs1;
        forward_ALUSrc2  <= sel_rs2_alu;
        forward_wdataSrc <= sel_rs2_st;
      end else begin
        ex_valid         <= 1'b0;
        ex_rd            <= '0;
        ex_regwrite      <= 1'b0;
        ex_load          <= 1'b0;
        forward_ALUSrc1  <= FWD_RF;
        forward_ALUSrc2  <= FWD_RF;
        forward_wdataSrc <= FWD_RF;
      end

      if (load_use) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_fwd_ctrl.sv
// tb/tb_ysyx_22050133_fwd_ctrl.sv - directed vector bench for the forwarding controller
module tb_ysyx_22050133_fwd_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_load;
  logic        id_store;
  logic        ex_redirect;
  logic        mem_stall;
  logic [1:0]  forward_ALUSrc1;
  logic [1:0]  forward_ALUSrc2;
  logic [1:0]  forward_wdataSrc;
  logic        stall_id;
  logic        bubble_ex;
  logic [63:0] stall_cnt;

  int tests_run;
  int tests_failed;

  ysyx_22050133_fwd_ctrl #(.REGW(5), .CNTW(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .id_rd            (id_rd),
    .id_regwrite      (id_regwrite),
    .id_load          (id_load),
    .id_store         (id_store),
    .ex_redirect      (ex_redirect),
    .mem_stall        (mem_stall),
    .forward_ALUSrc1  (forward_ALUSrc1),
    .forward_ALUSrc2  (forward_ALUSrc2),
    .forward_wdataSrc (forward_wdataSrc),
    .stall_id         (stall_id),
    .bubble_ex        (bubble_ex),
    .stall_cnt        (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        st;
    logic        e_stall;
    logic [1:0]  e_f1;
    logic [1:0]  e_f2;
    logic [1:0]  e_fw;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic rw, input logic ld, input logic st,
                              input logic e_stall, input int e_f1, input int e_f2,
                              input int e_fw, input int e_cnt);
    vec_t r;
    r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
    r.rd = 5'(rd); r.rw = rw; r.ld = ld; r.st = st;
    r.e_stall = e_stall; r.e_f1 = 2'(e_f1); r.e_f2 = 2'(e_f2);
    r.e_fw = 2'(e_fw); r.e_cnt = 64'(e_cnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                        input logic u2, input int rd, input logic rw, input logic ld,
                        input logic st);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_load = ld; id_store = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string tag, input int f1, input int f2, input int fw, input int cnt);
    chk({tag, " ALUSrc1"}, 64'(forward_ALUSrc1), 64'(f1));
    chk({tag, " ALUSrc2"}, 64'(forward_ALUSrc2), 64'(f2));
    chk({tag, " wdataSrc"}, 64'(forward_wdataSrc), 64'(fw));
    chk({tag, " stall_cnt"}, stall_cnt, 64'(cnt));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    ex_redirect  = 1'b0;
    mem_stall    = 1'b0;
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    //          v  rs1 rs2 u1 u2 rd  rw ld st | stall f1 f2 fw cnt
    vecs.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0)); // add x5,x1,x2
    vecs.push_back(mk(1,  5,  7, 1, 1,  6, 1, 0, 0, 0, 2, 0, 0, 0)); // sub x6,x5,x7
    vecs.push_back(mk(1,  5,  0, 1, 1,  8, 1, 0, 0, 0, 1, 0, 0, 0)); // or x8,x5,x0
    vecs.push_back(mk(1,  8,  0, 1, 0, 10, 1, 1, 0, 0, 2, 0, 0, 0)); // ld x10,0(x8)
    vecs.push_back(mk(1, 10, 10, 1, 1, 11, 1, 0, 0, 1, 0, 0, 0, 1)); // add x11,x10,x10 stalls
    vecs.push_back(mk(1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 1, 1, 0, 1)); // retried add
    vecs.push_back(mk(1, 11,  0, 1, 0,  9, 1, 0, 0, 0, 2, 0, 0, 1)); // addi x9,x11
    vecs.push_back(mk(1,  2,  9, 1, 1,  0, 0, 0, 1, 0, 0, 0, 2, 1)); // sd x9,0(x2)
    vecs.push_back(mk(1,  9,  9, 1, 1,  0, 0, 0, 1, 0, 1, 0, 1, 1)); // sd x9,8(x9)
    vecs.push_back(mk(1,  9,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 1)); // addi x0,x9
    vecs.push_back(mk(1,  0,  0, 1, 1,  0, 0, 0, 1, 0, 0, 0, 0, 1)); // sd x0,0(x0)
    vecs.push_back(mk(1,  1,  0, 1, 0, 14, 1, 1, 0, 0, 0, 0, 0, 1)); // ld x14
    vecs.push_back(mk(0, 14, 14, 1, 1, 15, 1, 0, 0, 0, 0, 0, 0, 1)); // invalid slot
    vecs.push_back(mk(1, 14,  0, 1, 0, 16, 1, 0, 0, 0, 1, 0, 0, 1)); // reads x14
    vecs.push_back(mk(1, 16, 16, 0, 0, 17, 1, 1, 0, 0, 0, 0, 0, 1)); // ld x17, sources unused
    vecs.push_back(mk(1, 17, 17, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1)); // unused sources, no stall
    vecs.push_back(mk(1, 17,  0, 1, 0, 18, 1, 0, 0, 0, 1, 0, 0, 1)); // reads x17
    vecs.push_back(mk(1,  2,  0, 1, 0, 19, 1, 1, 0, 0, 0, 0, 0, 1)); // ld x19
    vecs.push_back(mk(1,  2, 19, 1, 1,  0, 0, 0, 1, 1, 0, 0, 0, 2)); // sd x19 stalls
    vecs.push_back(mk(1,  2, 19, 1, 1,  0, 0, 0, 1, 0, 0, 0, 1, 2)); // retried sd

    #12;
    chk("reset stall_id", 64'(stall_id), 64'd0);
    chk("reset bubble_ex", 64'(bubble_ex), 64'd0);
    chk_sel("reset", 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_id(vecs[i].v, int'(vecs[i].rs1), int'(vecs[i].rs2), vecs[i].u1, vecs[i].u2,
             int'(vecs[i].rd), vecs[i].rw, vecs[i].ld, vecs[i].st);
      #1;
      chk($sformatf("v%0d stall_id", i), 64'(stall_id), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d bubble_ex", i), 64'(bubble_ex), 64'(vecs[i].e_stall));
      tick();
      chk_sel($sformatf("v%0d", i), int'(vecs[i].e_f1), int'(vecs[i].e_f2),
              int'(vecs[i].e_fw), int'(vecs[i].e_cnt));
    end

    // Flush beats load-use.
    set_id(1'b1, 2, 0, 1'b1, 1'b0, 20, 1'b1, 1'b1, 1'b0);     // ld x20
    tick();
    set_id(1'b1, 20, 0, 1'b1, 1'b0, 21, 1'b1, 1'b0, 1'b0);    // add x21,x20
    ex_redirect = 1'b1;
    #1;
    chk("flush stall_id", 64'(stall_id), 64'd0);
    tick();
    ex_redirect = 1'b0;
    chk_sel("flush", 0, 0, 0, 2);
    set_id(1'b1, 20, 21, 1'b1, 1'b1, 22, 1'b1, 1'b0, 1'b0);   // reads x20 and x21
    #1;
    chk("post-flush stall_id", 64'(stall_id), 64'd0);
    tick();
    chk_sel("post-flush", 1, 0, 0, 2);

    // Freeze during a pending RAW.
    set_id(1'b1, 22, 0, 1'b1, 1'b0, 23, 1'b1, 1'b0, 1'b0);    // reads x22
    tick();
    chk_sel("pre-freeze", 2, 0, 0, 2);
    set_id(1'b1, 22, 23, 1'b1, 1'b1, 24, 1'b1, 1'b0, 1'b0);   // reads x22 and x23
    mem_stall   = 1'b1;
    ex_redirect = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("freeze%0d stall_id", c), 64'(stall_id), 64'd0);
      chk($sformatf("freeze%0d bubble_ex", c), 64'(bubble_ex), 64'd0);
      tick();
      chk_sel($sformatf("freeze%0d", c), 2, 0, 0, 2);
    end
    mem_stall   = 1'b0;
    ex_redirect = 1'b0;
    tick();
    chk_sel("thaw", 1, 2, 0, 2);

    // Reset asserted while a load-use stall is pending.
    set_id(1'b1, 24, 0, 1'b1, 1'b0, 25, 1'b1, 1'b1, 1'b0);    // ld x25,0(x24)
    tick();
    chk_sel("pre-reset ld", 2, 0, 0, 2);
    set_id(1'b1, 25, 0, 1'b1, 1'b0, 26, 1'b1, 1'b0, 1'b0);    // add x26,x25
    #1;
    chk("pre-reset stall_id", 64'(stall_id), 64'd1);
    chk("pre-reset bubble_ex", 64'(bubble_ex), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("in-reset stall_id", 64'(stall_id), 64'd0);
    chk("in-reset bubble_ex", 64'(bubble_ex), 64'd0);
    chk_sel("in-reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release stall_id", 64'(stall_id), 64'd0);
    tick();
    chk_sel("release", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_fwd_ctrl.md
# ysyx_22050133_fwd_ctrl

Forwarding and hazard controller for the five-stage ysyx_22050133 core. It sits between ID and EX, producing the per-instruction bypass selects `forward_ALUSrc1`, `forward_ALUSrc2` and `forward_wdataSrc` that the execute unit consumes. It keeps a shadow pipeline of destination-register information for EX, MEM and WB. It also generates the load-use stall, the EX bubble and the flush handling.

## Interface
Parameters:
- `REGW`, 5: register index width.
- `CNTW`, 64: width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REGW  source indices.
- `id_use_rs1`, `id_use_rs2`  in  1  the instruction reads the source (includes csrrw/csrrs rs1).
- `id_rd`  in  REGW  destination index.
- `id_regwrite`  in  1  the instruction writes rd.
- `id_load`  in  1  the instruction is a load.
- `id_store`  in  1  the instruction is a store (rs2 is store data).
- `ex_redirect`  in  1  the EX instruction redirects PC (taken branch, jump, ecall, mret).
- `mem_stall`  in  1  the memory stage is busy; the whole pipeline freezes.
- `forward_ALUSrc1`  out  2  bypass select for ALU operand 1.
- `forward_ALUSrc2`  out  2  bypass select for ALU operand 2.
- `forward_wdataSrc`  out  2  bypass select for store data.
- `stall_id`  out  1  hold PC/IF/ID this cycle.
- `bubble_ex`  out  1  load a bubble into ID/EX at the next edge.
- `stall_cnt`  out  CNTW  count of load-use stall cycles.

## Operation
- Select encoding:
  - 0 = register-file data.
  - 1 = WB-stage data.
  - 2 = MEM-stage data.
  - 3 is never driven.
- Shadow slots `ex`, `mem`, `wb` each hold {valid, rd, regwrite, load}.
- A slot matches source `s` when all of these hold: slot valid, regwrite=1, rd≠0, rd==s, and the source is used.
- Select computation at ID, registered into the EX-aligned outputs. A source matching slot `ex` yields 2 (that producer will be in MEM). Otherwise a match on slot `mem` yields 1 (it will be in WB). Otherwise 0.
  - The newer producer wins.
  - The `wb` slot needs no bypass: the register file writes through on the same edge.
- Store handling:
  - `id_store`=1: rs2's select goes to `forward_wdataSrc`, and `forward_ALUSrc2` is 0 (the ALU uses imm).
  - Non-store: `forward_wdataSrc` is 0.
- Load-use: slot `ex` matches rs1 or rs2, `ex.load`=1, and `id_valid`=1. Then `stall_id`=1 and `bubble_ex`=1, both combinational in the same cycle.
  - The ID/EX entry becomes invalid with selects 0, and ID holds.
  - On the next cycle the load sits in `mem`, so the retried instruction gets select 1.
  - Exactly one bubble per load-use.
- Flush: `ex_redirect`=1 with `mem_stall`=0. The instruction entering EX becomes a bubble, `stall_id`=0, and load-use is suppressed (flush beats stall). The redirecting instruction itself advances to MEM normally.
- `mem_stall`=1 overrides everything:
  - all shadow slots, select outputs and `stall_cnt` hold;
  - `stall_id`=0 and `bubble_ex`=0;
  - `ex_redirect` is ignored, and the source holds it until `mem_stall` falls.
- `id_valid`=0 inserts a bubble with selects 0.
- `stall_cnt` increments by 1 on every edge where the load-use stall is taken. It wraps modulo 2^CNTW.

## Timing
- Reset (asynchronous assert, `rst`=0): all slots invalid, selects 0, `stall_cnt`=0. `stall_id`/`bubble_ex` evaluate to 0 because the slots are empty.
- Release is synchronous to `clk`; the first edge after release may capture an instruction.
- Select latency: computed in the ID cycle and valid for the full EX cycle, aligned with the `ctrl_ex` register.
- `stall_id` and `bubble_ex` are combinational from ID inputs and slot state, with zero latency.
- Slot shift on every non-frozen edge: `wb`←`mem`, `mem`←`ex`, `ex`←(ID entry or bubble).
- A `rst` assertion mid-stall clears the state immediately. No pending stall survives.

## Structure
- Shared constants go in `npcdefine.v`:
  - `ysyx_22050133_FWD_RF` = 2'd0
  - `ysyx_22050133_FWD_WB` = 2'd1
  - `ysyx_22050133_FWD_MEM` = 2'd2
  - a slot width define for {valid, rd, regwrite, load}
- One sub-module, `ysyx_22050133_fwd_match`: purely combinational. It compares one source index and use flag against the `ex` and `mem` slots and returns {sel[1:0], loaduse}. It is instantiated three times (rs1, rs2 for ALU, rs2 for store data).
- Top level holds the shadow slots, output registers, freeze/flush priority and counter.

## Test plan
- RAW chain: `add x5` then `sub x6,x5,x7`. Response: `forward_ALUSrc1`=2 in sub's EX. A third instruction `or x8,x5,x0` then gets `forward_ALUSrc1`=1.
- Load-use: `ld x5` then `add x6,x5,x5`. Response: `stall_id`=1 and `bubble_ex`=1 for one cycle, `stall_cnt` 0→1. Add's EX then sees both selects = 1.
- Store data: `addi x9` then `sd x9,0(x2)`. Response: `forward_wdataSrc`=2 and `forward_ALUSrc2`=0. With rd=0 (`addi x0`), all selects are 0.
- Flush beats stall: `ex_redirect`=1 in the same cycle a load-use is detected. Response: `stall_id`=0, the EX slot is a bubble, and `stall_cnt` is unchanged.
- Freeze: `mem_stall`=1 for 3 cycles during a pending RAW. Response: outputs and slots hold, `ex_redirect` is ignored, and forwarding resumes with identical selects.
- Reset mid-stall: drive `rst`=0 during a load-use cycle. Response: selects and `stall_cnt` are 0 immediately, with no bubble after release.
